// File: rtl/madd_operand_collector.sv
// -----------------------------------------------------------------------------
// madd_operand_collector
//
// Serial-to-parallel feeder for the 8-input combinational adder `cadder`.
// Operands arrive one per cycle on a valid/ready stream. When N_OPS of them
// have been captured they are presented in parallel on `ops`. They are held
// there for SETTLE_CYCLES cycles so the adder output can settle. The adder
// result is then registered and offered downstream on a valid/ready handshake.
//
// Optional feature (macro MADD_SELF_CHECK_EN):
//   When defined, a running modulo sum of the accepted operands is compared
//   with the adder result at the sample edge. Any difference sets the sticky
//   err_mismatch flag. When undefined, err_mismatch is tied low.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand stream valid
//   in_data      in   operand value [WIDTH]
//   in_ready     out  collector can accept an operand
//   ops          out  parallel operands [N_OPS*WIDTH], operand k at [k*WIDTH +: WIDTH]
//   sum_in       in   combinational adder result [WIDTH]
//   res_valid    out  result register holds an unconsumed sum
//   res_data     out  registered sum [WIDTH]
//   res_ready    in   downstream accepts the result
//   busy         out  round in progress (not idle in COLLECT with zero operands)
//   err_mismatch out  sticky self-check flag
// -----------------------------------------------------------------------------
module madd_operand_collector #(
  parameter int WIDTH         = 8,
  parameter int N_OPS         = 8,  // adder has exactly 8 inputs
  parameter int SETTLE_CYCLES = 2   // must be >= 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [N_OPS*WIDTH-1:0] ops,
  input  logic [WIDTH-1:0]       sum_in,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   err_mismatch
);

  localparam int CW  = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_SLOT   = CW'(N_OPS - 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SETTLE  = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            count_q;
  logic [SCW-1:0]           settle_q;
  logic [N_OPS*WIDTH-1:0]   ops_q;
  logic [WIDTH-1:0]         res_data_q;
  logic                     res_valid_q;
  logic                     err_q;
`ifdef MADD_SELF_CHECK_EN
  logic [WIDTH-1:0]         run_sum_q;
`endif

  // Collector FSM: operand capture, settle countdown, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      settle_q    <= '0;
      ops_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef MADD_SELF_CHECK_EN
      run_sum_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_COLLECT: begin
          // in_ready is high throughout COLLECT, so in_valid alone accepts.
          if (in_valid) begin
            ops_q[count_q*WIDTH +: WIDTH] <= in_data;
`ifdef MADD_SELF_CHECK_EN
            // Slot 0 starts a new round, so the running sum restarts there.
            run_sum_q <= (count_q == '0) ? in_data : (run_sum_q + in_data);
`endif
            if (count_q == LAST_SLOT) begin
              count_q  <= '0;
              settle_q <= SETTLE_LOAD;
              state_q  <= S_SETTLE;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            res_data_q  <= sum_in;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
`ifdef MADD_SELF_CHECK_EN
            if (run_sum_q != sum_in) begin
              err_q <= 1'b1;
            end
`endif
          end else begin
            settle_q <= settle_q - SCW'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_COLLECT;
          end
        end
        default: begin
          state_q <= S_COLLECT;
        end
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset interval.
  assign in_ready     = rst_n & (state_q == S_COLLECT);
  assign ops          = ops_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign busy         = (count_q != '0) | (state_q != S_COLLECT);
  assign err_mismatch = err_q;

endmodule

// File: tb/tb_madd_operand_collector.sv
// -----------------------------------------------------------------------------
// Testbench for madd_operand_collector.
//
// The bench models the adder as the modulo sum of `ops`, with an override that
// forces the sum to zero. A cycle-level reference model predicts every output
// from the behavioural rules: the accept count, the settle latency after the
// last accept, and the result hold. These predictions are compared with the
// DUT every cycle. Literal expected results pin each round.
// -----------------------------------------------------------------------------
module tb_madd_operand_collector;

  localparam int W = 8;
  localparam int N = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           res_ready = 1'b0;
  logic           force_zero = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] ops;
  logic [W-1:0]   sum_in;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic           busy;
  logic           err_mismatch;

  int tests = 0;
  int fails = 0;

  madd_operand_collector #(.WIDTH(W), .N_OPS(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ops(ops), .sum_in(sum_in), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy),
    .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sum_ops(input logic [N*W-1:0] v);
    logic [W-1:0] a;
    a = '0;
    for (int k = 0; k < N; k++) a = a + v[k*W +: W];
    return a;
  endfunction

  // Stand-in for the combinational adder.
  assign sum_in = force_zero ? '0 : sum_ops(ops);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_cnt;
  logic [W-1:0] m_slot [N];
  int           m_phase;   // 0 collecting, 1 waiting on settle, 2 result held
  int           m_wait;
  logic         m_rv;
  logic [W-1:0] m_rd;
  logic         m_err;
  logic         prv;
  logic [W-1:0] prd;
  logic [W-1:0] got_q [$];

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_wait = 0; m_rv = 1'b0; m_rd = '0; m_err = 1'b0;
    prv = 1'b0; prd = '0;
    for (int k = 0; k < N; k++) m_slot[k] = '0;
  endtask

  initial begin
    logic [N*W-1:0] exp_ops;
    logic [W-1:0]   s;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (prv && res_ready) got_q.push_back(prd);
        case (m_phase)
          0: if (in_valid) begin
               m_slot[m_cnt] = in_data;
               m_cnt++;
               if (m_cnt == N) begin
                 m_cnt = 0; m_phase = 1; m_wait = 0;
               end
             end
          1: begin
               m_wait++;
               if (m_wait == S) begin
                 s = '0;
                 for (int k = 0; k < N; k++) s = s + m_slot[k];
                 m_rd = force_zero ? '0 : s;
`ifdef MADD_SELF_CHECK_EN
                 if (force_zero && s != '0) m_err = 1'b1;
`endif
                 m_rv = 1'b1; m_phase = 2;
               end
             end
          default: if (res_ready) begin
               m_rv = 1'b0; m_phase = 0;
             end
        endcase
      end
      #1;
      for (int k = 0; k < N; k++) exp_ops[k*W +: W] = m_slot[k];
      chk("in_ready", in_ready, rst_n && m_phase == 0);
      chk("busy", busy, (m_cnt != 0) || (m_phase != 0));
      chk("res_valid", res_valid, m_rv);
      chk("res_data", res_data, m_rd);
      chk("err_mismatch", err_mismatch, m_err);
      chk("ops", ops, exp_ops);
      prv = res_valid;
      prd = res_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [W-1:0] v, input int gap, output int waits);
    logic acc;
    logic ok;
    ok = 1'b0;
    waits = 0;
    repeat (gap) begin in_valid = 1'b0; tick(); end
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 60; t++) begin
      acc = in_ready;
      tick();
      if (acc) begin ok = 1'b1; break; end
      waits++;
    end
    chk("send_timeout", ok, 1'b1);
  endtask

  task automatic collect_result(input int hold);
    logic ok;
    ok = 1'b0;
    res_ready = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (res_valid) begin ok = 1'b1; break; end
      tick();
    end
    chk("result_timeout", ok, 1'b1);
    for (int t = 0; t < hold; t++) begin
      in_valid = t[0];
      in_data  = 8'hAA;
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] exp);
    if (got_q.size() == 0) chk({name, "_missing"}, 1'b0, 1'b1);
    else chk(name, got_q.pop_front(), exp);
  endtask

  initial begin
    int w;
    logic exp_err;
`ifdef MADD_SELF_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_ops", ops, 64'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Reset in the middle of a round.
    for (int i = 0; i < 5; i++) send(W'(10 + i), 0, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(W'(i), 0, w);
    in_valid = 1'b0;
    collect_result(0);
    expect_result("sum_0_to_7", 8'd28);
    chk("model_pin_28", m_rd, 8'd28);

    // Ones with gaps between beats.
    for (int i = 0; i < 8; i++) send(8'd1, 2, w);
    in_valid = 1'b0;
    collect_result(0);
    expect_result("sum_ones", 8'd8);

    // Backpressure held for 10 cycles with in_valid pulses during HOLD.
    send(8'd3, 0, w);
    for (int i = 1; i < 8; i++) send(W'(i), 0, w);
    in_valid = 1'b0;
    collect_result(10);
    expect_result("sum_backpressure", 8'd31);
    chk("after_hold_busy", busy, 1'b0);

    // Wrap-around.
    for (int i = 0; i < 8; i++) send(8'd255, 0, w);
    in_valid = 1'b0;
    collect_result(0);
    expect_result("sum_wrap", 8'd248);
    chk("wrap_no_err", err_mismatch, 1'b0);

    // Forced-wrong adder result.
    force_zero = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(i), 0, w);
    in_valid = 1'b0;
    collect_result(0);
    force_zero = 1'b0;
    expect_result("sum_forced", 8'd0);
    chk("err_after_forced", err_mismatch, exp_err);
    for (int i = 0; i < 8; i++) send(W'(i), 0, w);
    in_valid = 1'b0;
    collect_result(0);
    expect_result("sum_after_forced", 8'd28);
    chk("err_sticky", err_mismatch, exp_err);

    // Back-to-back rounds, in_valid and res_ready tied high.
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(i), 0, w);
    send(8'd1, 0, w);
    chk("b2b_gap_cycles", w, S + 1);
    for (int i = 1; i < 8; i++) send(8'd1, 0, w);
    for (int t = 0; t < 60 && got_q.size() < 2; t++) tick();
    in_valid  = 1'b0;
    res_ready = 1'b0;
    expect_result("b2b_first", 8'd28);
    expect_result("b2b_second", 8'd8);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/madd_operand_collector.md
Name: madd_operand_collector

Overview:
- Upstream feeder for the 8-operand combinational multi-operand adder `cadder`.
- Accepts operands serially, one per cycle, over a valid/ready stream.
- Once N_OPS operands are captured, presents them in parallel to the adder and waits a fixed settle time.
- Then registers the adder sum and offers it downstream on a valid/ready result handshake.

Parameters:
- WIDTH, 8: operand and sum width in bits.
- N_OPS, 8: operands per addition; the adder has 8 inputs, so only 8 is supported.
- SETTLE_CYCLES, 2: cycles operands are held stable before the sum is sampled; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand stream valid.
- in_data  in  WIDTH  operand value.
- in_ready  out  1  collector can accept an operand.
- ops  out  N_OPS*WIDTH  parallel operands to the adder; operand k at bits [k*WIDTH +: WIDTH]; k=0 drives m ... k=7 drives t.
- sum_in  in  WIDTH  adder result u (combinational, from the adder).
- res_valid  out  1  result register holds an unconsumed sum.
- res_data  out  WIDTH  registered sum.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than COLLECT with zero operands captured.
- err_mismatch  out  1  sticky self-check flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, on rst_n low): all of the following clear immediately.
  - state=COLLECT, count=0, settle counter=0.
  - ops=0, res_data=0, res_valid=0, err_mismatch=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
  - An operation in progress is discarded.
- States:
  - COLLECT:
    - in_ready=1.
    - An operand is accepted on a cycle with in_valid&in_ready; in_data is written to slot count and count increments.
    - On acceptance of slot N_OPS-1: count returns to 0, go to SETTLE, settle counter loads SETTLE_CYCLES-1.
  - SETTLE:
    - in_ready=0; ops held constant.
    - Settle counter decrements each cycle.
    - When it is 0: capture sum_in into res_data, set res_valid=1, go to HOLD.
  - HOLD:
    - in_ready=0; ops held; res_valid=1; res_data stable.
    - On res_valid&res_ready: res_valid clears on the next edge and state returns to COLLECT.
- Slot handling:
  - Unwritten slots keep their previous value; every slot is overwritten each round before use.
  - ops is not cleared between rounds.
- Latency:
  - The last operand is accepted at edge E; res_valid rises at edge E+SETTLE_CYCLES.
  - Minimum round with res_ready tied high: N_OPS + SETTLE_CYCLES + 1 cycles.
- Back-to-back:
  - The HOLD→COLLECT transition takes one cycle.
  - in_ready is 0 on the cycle res_ready is accepted.
  - in_ready is 1 on the following cycle.
- Arithmetic: the sum is modulo 2^WIDTH. The adder drops carries above WIDTH; the collector does not widen or flag it.
- in_valid stalls (in_valid=0) in COLLECT: count and slots hold, no timeout.
- res_ready held low in HOLD: wait indefinitely, all outputs stable.
- res_ready outside HOLD is ignored; in_valid outside COLLECT is ignored (not accepted, not buffered).
- busy=1 when count≠0 or state≠COLLECT.

Optional Feature:
- Macro: MADD_SELF_CHECK_EN.
- Defined:
  - The collector keeps a running WIDTH-bit modulo sum of accepted operands, reset to 0 at the start of each round.
  - At the SETTLE sample edge it compares the running sum with sum_in.
  - On inequality err_mismatch is set and stays set until reset. The result is still delivered unchanged.
- Undefined: no running-sum logic; err_mismatch is tied 0.

Test Plan:
- Reset mid-round, then recovery:
  - Feed 5 operands, assert rst_n=0 for one cycle → count=0, in_ready=0 during reset, res_valid=0, busy=0.
  - Then feed 0,1,2,3,4,5,6,7 with res_ready=1 → res_data=28 one cycle after res_valid rises, round completes.
- Operands 1×8 with in_valid gaps between beats → res_data=8; res_valid rises exactly SETTLE_CYCLES cycles after the eighth accept.
- Operands 3,1,2,3,4,5,6,7 with res_ready held 0 for 10 cycles:
  - res_valid=1 and res_data=31 stay stable throughout.
  - in_ready=0 throughout.
  - in_valid pulses during HOLD are not counted.
- Wrap-around: eight operands of 255 → res_data=248; no error flag with MADD_SELF_CHECK_EN defined.
- Self-check (MADD_SELF_CHECK_EN defined):
  - Force sum_in to 0 while feeding 0..7 → err_mismatch=1 after the sample edge, and it persists through the next correct round.
  - Compiled without the macro → err_mismatch=0.
- Back-to-back rounds:
  - Two rounds with in_valid and res_ready tied 1 → results 28 then 8.
  - in_ready=0 for exactly SETTLE_CYCLES+1 cycles between rounds.
  - ops equals the new operands only after all 8 are written.
